// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit (shift-add multiplier, restoring divider)
// One bit per cycle over a 2*XLEN accumulator; signed ops run on magnitudes and fix the sign at the end.
module muldiv_unit #(
   parameter int XLEN        = 32,
   parameter int SUPPORT_DIV = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid_i,
   output logic            op_ready_o,
   input  logic [2:0]      op_f3_i,
   input  logic [XLEN-1:0] op_rs1_i,
   input  logic [XLEN-1:0] op_rs2_i,
   input  logic [4:0]      op_rd_addr_i,
   input  logic            flush_i,
   output logic            res_valid_o,
   input  logic            res_ready_i,
   output logic [XLEN-1:0] res_data_o,
   output logic [4:0]      res_rd_addr_o,
   output logic            illegal_o,
   output logic            busy_o
);
   localparam int   CW      = $clog2(XLEN);
   localparam logic HAS_DIV = (SUPPORT_DIV != 0);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e              state_q;
   logic [CW-1:0]       cnt_q;
   logic [1:0]          f3_q;
   logic [4:0]          tag_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [XLEN-1:0]     opb_q;
   logic                neg_q;
   logic [XLEN-1:0]     res_q;
   logic                illegal_q;

   logic                a_neg_d, b_neg_d, neg_d;
   logic [XLEN-1:0]     a_mag_d, b_mag_d;
   logic                div_zero_d, div_ovf_d;
   logic [XLEN:0]       mul_sum_d;
   logic [XLEN:0]       rem_shift_d;
   logic [XLEN-1:0]     div_diff_d;
   logic [2*XLEN-1:0]   mul_acc_d, div_acc_d, step_acc_d, prod_fix_d;
   logic [XLEN-1:0]     quo_d, rem_d, final_d;

   assign op_ready_o    = (state_q == S_IDLE) && !flush_i;
   assign res_valid_o   = (state_q == S_DONE);
   assign busy_o        = (state_q != S_IDLE);
   assign res_data_o    = res_q;
   assign res_rd_addr_o = tag_q;
   assign illegal_o     = illegal_q;

   // Operand signedness: MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed.
   always_comb begin
      a_neg_d    = 1'b0;
      b_neg_d    = 1'b0;
      case (op_f3_i)
         3'b001, 3'b100, 3'b110: begin
            a_neg_d = op_rs1_i[XLEN-1];
            b_neg_d = op_rs2_i[XLEN-1];
         end
         3'b010:  a_neg_d = op_rs1_i[XLEN-1];
         default: ;
      endcase
      a_mag_d    = a_neg_d ? -op_rs1_i : op_rs1_i;
      b_mag_d    = b_neg_d ? -op_rs2_i : op_rs2_i;
      neg_d      = (op_f3_i[2] && op_f3_i[1]) ? a_neg_d : (a_neg_d ^ b_neg_d);
      div_zero_d = (op_rs2_i == '0);
      div_ovf_d  = !op_f3_i[0] && (op_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_rs2_i == '1);
   end

   always_comb begin
      mul_sum_d   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      mul_acc_d   = {mul_sum_d, acc_q[XLEN-1:1]};
      rem_shift_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff_d  = rem_shift_d[XLEN-1:0] - opb_q;
      if (rem_shift_d >= {1'b0, opb_q})
         div_acc_d = {div_diff_d, acc_q[XLEN-2:0], 1'b1};
      else
         div_acc_d = {rem_shift_d[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      step_acc_d  = (state_q == S_DIV) ? div_acc_d : mul_acc_d;
      prod_fix_d  = neg_q ? -step_acc_d : step_acc_d;
      quo_d       = step_acc_d[XLEN-1:0];
      rem_d       = step_acc_d[2*XLEN-1:XLEN];
      if (state_q == S_DIV)
         final_d = f3_q[1] ? (neg_q ? -rem_d : rem_d) : (neg_q ? -quo_d : quo_d);
      else
         final_d = (f3_q == 2'b00) ? prod_fix_d[XLEN-1:0] : prod_fix_d[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         f3_q      <= '0;
         tag_q     <= '0;
         acc_q     <= '0;
         opb_q     <= '0;
         neg_q     <= 1'b0;
         res_q     <= '0;
         illegal_q <= 1'b0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (op_valid_i) begin
                  f3_q      <= op_f3_i[1:0];
                  tag_q     <= op_rd_addr_i;
                  cnt_q     <= CW'(XLEN - 1);
                  acc_q     <= {{XLEN{1'b0}}, a_mag_d};
                  opb_q     <= b_mag_d;
                  neg_q     <= neg_d;
                  illegal_q <= 1'b0;
                  if (op_f3_i[2] && !HAS_DIV) begin
                     res_q     <= '0;
                     illegal_q <= 1'b1;
                     state_q   <= S_DONE;
                  end else if (op_f3_i[2] && div_zero_d) begin
                     res_q   <= op_f3_i[1] ? op_rs1_i : '1;
                     state_q <= S_DONE;
                  end else if (op_f3_i[2] && div_ovf_d) begin
                     res_q   <= op_f3_i[1] ? '0 : op_rs1_i;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= op_f3_i[2] ? S_DIV : S_MUL;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= step_acc_d;
               if (cnt_q == '0) begin
                  res_q   <= final_d;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready_i)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
// Main instance XLEN=32 with divider; a second XLEN=8 instance without divider.
module tb_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        op_valid = 1'b0, op_ready;
   logic [2:0]  op_f3 = '0;
   logic [31:0] op_rs1 = '0, op_rs2 = '0;
   logic [4:0]  op_rd = '0;
   logic        flush = 1'b0;
   logic        res_valid, res_ready = 1'b0;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        illegal, busy;

   logic        v2 = 1'b0, ready2, res_valid2, res_ready2 = 1'b0, illegal2, busy2;
   logic        flush2 = 1'b0;
   logic [7:0]  res_data2;
   logic [4:0]  res_rd2;

   int errors = 0;
   int checks = 0;
   int lat;
   logic seen;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .SUPPORT_DIV(1)) dut (
      .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_ready_o(op_ready),
      .op_f3_i(op_f3), .op_rs1_i(op_rs1), .op_rs2_i(op_rs2), .op_rd_addr_i(op_rd),
      .flush_i(flush), .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_data_o(res_data), .res_rd_addr_o(res_rd), .illegal_o(illegal), .busy_o(busy)
   );

   muldiv_unit #(.XLEN(8), .SUPPORT_DIV(0)) dut_nd (
      .clk(clk), .rst(rst), .op_valid_i(v2), .op_ready_o(ready2),
      .op_f3_i(op_f3), .op_rs1_i(op_rs1[7:0]), .op_rs2_i(op_rs2[7:0]), .op_rd_addr_i(op_rd),
      .flush_i(flush2), .res_valid_o(res_valid2), .res_ready_i(res_ready2),
      .res_data_o(res_data2), .res_rd_addr_o(res_rd2), .illegal_o(illegal2), .busy_o(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns just after the accepting posedge.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      op_f3 = f3; op_rs1 = a; op_rs2 = b; op_rd = rd; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
   endtask

   // Number of negedges after the accept edge until res_valid is seen (bounded).
   task automatic wait_res(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (res_valid) break;
      end
   endtask

   task automatic consume(input string tag);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_valid_drop"}, {31'b0, res_valid}, 32'h0);
      chk({tag, "_ready_back"}, {31'b0, op_ready}, 32'h1);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int n;
      issue(f3, a, b, rd);
      wait_res(n);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_data"}, res_data, exp);
      chk({tag, "_tag"}, {27'b0, res_rd}, {27'b0, rd});
      chk({tag, "_illegal"}, {31'b0, illegal}, 32'h0);
      consume(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", {31'b0, res_valid}, 32'h0);
      chk("rst_data", res_data, 32'h0);
      chk("rst_tag", {27'b0, res_rd}, 32'h0);
      chk("rst_illegal", {31'b0, illegal}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_ready", {31'b0, op_ready}, 32'h1);

      // Multiplies
      run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
      run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 33);
      run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33);

      // Divides, including divide-by-zero and signed overflow
      run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
      run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
      run_op("div_pos_neg", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33);
      run_op("divu", 3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 33);
      run_op("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 33);
      run_op("divu_z", 3'b101, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1);
      run_op("remu_z", 3'b111, 32'd5, 32'd0, 5'd15, 32'd5, 1);
      run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
      run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 1);

      // Flush mid-divide, with a competing request offered during the flush
      issue(3'b100, 32'd1000, 32'd3, 5'd18);
      repeat (9) @(negedge clk);
      chk("flush_busy_before", {31'b0, busy}, 32'h1);
      flush = 1'b1; op_valid = 1'b1; op_f3 = 3'b000;
      #1 chk("flush_blocks_ready", {31'b0, op_ready}, 32'h0);
      @(posedge clk);
      #1 flush = 1'b0; op_valid = 1'b0;
      @(negedge clk);
      chk("flush_idle", {31'b0, busy}, 32'h0);
      chk("flush_no_valid", {31'b0, res_valid}, 32'h0);
      run_op("after_flush", 3'b101, 32'd1000, 32'd3, 5'd19, 32'd333, 33);

      // Back-pressure in DONE
      issue(3'b000, 32'd3, 32'd4, 5'd20);
      wait_res(lat);
      chk("bp_lat", lat, 33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_held", {31'b0, res_valid}, 32'h1);
         chk("bp_data_stable", res_data, 32'd12);
         chk("bp_tag_stable", {27'b0, res_rd}, 32'd20);
         chk("bp_not_ready", {31'b0, op_ready}, 32'h0);
      end
      consume("bp");

      // Flush in DONE while the consumer is not ready
      issue(3'b101, 32'd5, 32'd0, 5'd21);
      @(negedge clk);
      chk("fdone_valid", {31'b0, res_valid}, 32'h1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("fdone_dropped", {31'b0, res_valid}, 32'h0);
      chk("fdone_ready", {31'b0, op_ready}, 32'h1);

      // Reset in the middle of a multiply discards it
      issue(3'b000, 32'd9, 32'd9, 5'd22);
      repeat (11) @(negedge clk);
      flush = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("mrst_valid", {31'b0, res_valid}, 32'h0);
      chk("mrst_data", res_data, 32'h0);
      chk("mrst_tag", {27'b0, res_rd}, 32'h0);
      chk("mrst_illegal", {31'b0, illegal}, 32'h0);
      chk("mrst_busy", {31'b0, busy}, 32'h0);
      chk("mrst_ready", {31'b0, op_ready}, 32'h1);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      chk("mrst_no_result", {31'b0, seen}, 32'h0);

      // Divider-less 8-bit instance: divide is illegal, multiply still works
      op_f3 = 3'b100; op_rs1 = 32'd20; op_rs2 = 32'd3; op_rd = 5'd23; v2 = 1'b1;
      @(posedge clk);
      #1 v2 = 1'b0;
      @(negedge clk);
      chk("nd_valid", {31'b0, res_valid2}, 32'h1);
      chk("nd_illegal", {31'b0, illegal2}, 32'h1);
      chk("nd_data", {24'b0, res_data2}, 32'h0);
      chk("nd_tag", {27'b0, res_rd2}, 32'd23);
      res_ready2 = 1'b1;
      @(posedge clk);
      #1 res_ready2 = 1'b0;
      op_f3 = 3'b000; op_rs1 = 32'd13; op_rs2 = 32'd11; op_rd = 5'd24; v2 = 1'b1;
      @(posedge clk);
      #1 v2 = 1'b0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (res_valid2) break;
      end
      chk("nd_mul_lat", lat, 9);
      chk("nd_mul_data", {24'b0, res_data2}, 32'h8F);
      chk("nd_mul_illegal", {31'b0, illegal2}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
